// File: rtl/model_store_pkg.sv
// Shared types for the model store: loader table select, corner entry layout,
// attribute vector and the vertex fetch sequencer states.
package model_pkg;

   localparam int ID_W   = 12;
   localparam int COMP_W = 32;

   typedef enum logic [1:0] {
      CORNER   = 2'd0,
      POSITION = 2'd1,
      NORMAL   = 2'd2,
      MATERIAL = 2'd3
   } wr_sel_t;

   typedef struct packed {
      logic [ID_W-1:0] mat_id;
      logic [ID_W-1:0] nrm_id;
      logic [ID_W-1:0] pos_id;
   } corner_t;

   typedef logic [2:0][COMP_W-1:0] attr_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      IDX_WAIT  = 2'd1,
      ATTR_WAIT = 2'd2,
      EMIT      = 2'd3
   } state_t;

   // Corner index 3t+c, widened by two bits so out-of-range ids stay visible.
   function automatic logic [ID_W+1:0] corner_addr(input logic [ID_W-1:0] t,
                                                   input logic [1:0]      c);
      return ({2'b00, t} * (ID_W + 2)'(3)) + {{ID_W{1'b0}}, c};
   endfunction

endpackage

// File: rtl/model_store_ram.sv
// Single-port RAM with a fixed read pipeline of LATENCY registers.
module xilinx_single_port_ram #(
   parameter int DEPTH   = 1024,
   parameter int WIDTH   = 96,
   parameter int LATENCY = 2,
   parameter int AW      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem  [DEPTH];
   logic [WIDTH-1:0] pipe [LATENCY];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
      pipe[0] <= mem[addr];
      for (int i = 1; i < LATENCY; i++) begin
         pipe[i] <= pipe[i-1];
      end
   end

   assign dout = pipe[LATENCY-1];

endmodule

// File: rtl/model_store.sv
// Writable triangle/vertex tables with a sequencer that expands a triangle id
// into three resolved vertex beats (position, normal, material).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | loader owns the RAMs; accepts writes and triangle requests
// IDX_WAIT  | corner entry 3t+c read in flight
// ATTR_WAIT | position/normal/material reads in flight
// EMIT      | vertex beat held until downstream accepts it
module model_store
   import model_pkg::*;
#(
   parameter int CORNER_DEPTH = 4096,
   parameter int VTX_DEPTH    = 1024,
   parameter int MAT_DEPTH    = 8,
   parameter int ID_WIDTH     = ID_W,
   parameter int COMP_WIDTH   = COMP_W,
   parameter int RAM_LATENCY  = 2
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         wr_valid_in,
   output logic                         wr_ready_out,
   input  logic [1:0]                   wr_sel_in,
   input  logic [ID_WIDTH-1:0]          wr_addr_in,
   input  logic [3*COMP_WIDTH-1:0]      wr_data_in,
   input  logic                         tri_valid_in,
   output logic                         tri_ready_out,
   input  logic [ID_WIDTH-1:0]          tri_id_in,
   output logic                         vtx_valid_out,
   input  logic                         vtx_ready_in,
   output logic [2:0][COMP_WIDTH-1:0]   vtx_position_out,
   output logic [2:0][COMP_WIDTH-1:0]   vtx_normal_out,
   output logic [2:0][COMP_WIDTH-1:0]   vtx_material_out,
   output logic                         vtx_last_out,
   output logic                         err_out
);

   localparam int CAW = $clog2(CORNER_DEPTH);
   localparam int VAW = $clog2(VTX_DEPTH);
   localparam int MAW = $clog2(MAT_DEPTH);
   localparam int CW  = 3 * ID_WIDTH;
   localparam int DW  = 3 * COMP_WIDTH;

   state_t              state, state_nxt;
   logic [ID_WIDTH-1:0] tri_q;
   logic [1:0]          c_q;
   logic [7:0]          cnt_q;
   corner_t             corner_q;

   logic                idle;
   logic                wr_fire, tri_fire, vtx_fire;
   logic                wr_bad, tri_bad;
   wr_sel_t             wr_sel;
   logic [31:0]         wr_depth;
   logic [ID_WIDTH+1:0] tri_last_addr;
   logic [ID_WIDTH+1:0] seq_addr;

   logic [CAW-1:0]      corner_ram_addr;
   logic [VAW-1:0]      pos_ram_addr, nrm_ram_addr;
   logic [MAW-1:0]      mat_ram_addr;
   logic                we_corner, we_pos, we_nrm, we_mat;
   logic [CW-1:0]       corner_dout;
   logic [DW-1:0]       pos_dout, nrm_dout, mat_dout;

   assign idle          = (state == IDLE);
   assign wr_ready_out  = idle & wr_valid_in;
   assign tri_ready_out = idle & tri_valid_in & ~wr_valid_in;
   assign wr_fire       = wr_ready_out;
   assign tri_fire      = tri_ready_out;
   assign vtx_fire      = (state == EMIT) & vtx_ready_in;
   assign wr_sel        = wr_sel_t'(wr_sel_in);

   always_comb begin
      wr_depth = 32'(CORNER_DEPTH);
      unique case (wr_sel)
         CORNER:   wr_depth = 32'(CORNER_DEPTH);
         POSITION: wr_depth = 32'(VTX_DEPTH);
         NORMAL:   wr_depth = 32'(VTX_DEPTH);
         MATERIAL: wr_depth = 32'(MAT_DEPTH);
         default:  wr_depth = 32'(CORNER_DEPTH);
      endcase
   end

   assign wr_bad        = {{(32-ID_WIDTH){1'b0}}, wr_addr_in} >= wr_depth;
   assign tri_last_addr = corner_addr(tri_id_in, 2'd2);
   assign tri_bad       = {{(30-ID_WIDTH){1'b0}}, tri_last_addr} >= 32'(CORNER_DEPTH);

   // The corner read for the next corner is issued on the transition edge
   // itself, so the index lookup overlaps the accepting handshake.
   always_comb begin
      seq_addr = corner_addr(tri_q, c_q);
      if (tri_fire) begin
         seq_addr = corner_addr(tri_id_in, 2'd0);
      end else if (vtx_fire && c_q != 2'd2) begin
         seq_addr = corner_addr(tri_q, 2'(c_q + 2'd1));
      end
   end

   assign corner_ram_addr = wr_fire ? wr_addr_in[CAW-1:0] : seq_addr[CAW-1:0];
   assign pos_ram_addr    = wr_fire ? wr_addr_in[VAW-1:0] : corner_q.pos_id[VAW-1:0];
   assign nrm_ram_addr    = wr_fire ? wr_addr_in[VAW-1:0] : corner_q.nrm_id[VAW-1:0];
   assign mat_ram_addr    = wr_fire ? wr_addr_in[MAW-1:0] : corner_q.mat_id[MAW-1:0];

   assign we_corner = wr_fire & ~wr_bad & (wr_sel == CORNER);
   assign we_pos    = wr_fire & ~wr_bad & (wr_sel == POSITION);
   assign we_nrm    = wr_fire & ~wr_bad & (wr_sel == NORMAL);
   assign we_mat    = wr_fire & ~wr_bad & (wr_sel == MATERIAL);

   xilinx_single_port_ram #(.DEPTH(CORNER_DEPTH), .WIDTH(CW), .LATENCY(RAM_LATENCY)) u_corner_ram (
      .clk  (clk_in),
      .we   (we_corner),
      .addr (corner_ram_addr),
      .din  (wr_data_in[CW-1:0]),
      .dout (corner_dout)
   );

   xilinx_single_port_ram #(.DEPTH(VTX_DEPTH), .WIDTH(DW), .LATENCY(RAM_LATENCY)) u_pos_ram (
      .clk  (clk_in),
      .we   (we_pos),
      .addr (pos_ram_addr),
      .din  (wr_data_in),
      .dout (pos_dout)
   );

   xilinx_single_port_ram #(.DEPTH(VTX_DEPTH), .WIDTH(DW), .LATENCY(RAM_LATENCY)) u_nrm_ram (
      .clk  (clk_in),
      .we   (we_nrm),
      .addr (nrm_ram_addr),
      .din  (wr_data_in),
      .dout (nrm_dout)
   );

   xilinx_single_port_ram #(.DEPTH(MAT_DEPTH), .WIDTH(DW), .LATENCY(RAM_LATENCY)) u_mat_ram (
      .clk  (clk_in),
      .we   (we_mat),
      .addr (mat_ram_addr),
      .din  (wr_data_in),
      .dout (mat_dout)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (tri_fire && !tri_bad) state_nxt = IDX_WAIT;
         IDX_WAIT:  if (cnt_q == 8'd0)        state_nxt = ATTR_WAIT;
         ATTR_WAIT: if (cnt_q == 8'd0)        state_nxt = EMIT;
         EMIT:      if (vtx_ready_in)         state_nxt = (c_q == 2'd2) ? IDLE : IDX_WAIT;
         default:                             state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         tri_q            <= '0;
         c_q              <= '0;
         cnt_q            <= '0;
         corner_q         <= '0;
         vtx_valid_out    <= 1'b0;
         vtx_last_out     <= 1'b0;
         vtx_position_out <= '0;
         vtx_normal_out   <= '0;
         vtx_material_out <= '0;
         err_out          <= 1'b0;
      end else begin
         err_out <= (wr_fire & wr_bad) | (tri_fire & tri_bad);
         unique case (state)
            IDLE: begin
               if (tri_fire && !tri_bad) begin
                  tri_q <= tri_id_in;
                  c_q   <= 2'd0;
                  cnt_q <= 8'(RAM_LATENCY - 1);
               end
            end
            IDX_WAIT: begin
               if (cnt_q == 8'd0) begin
                  corner_q <= corner_t'(corner_dout);
                  cnt_q    <= 8'(RAM_LATENCY);
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            ATTR_WAIT: begin
               if (cnt_q == 8'd0) begin
                  vtx_position_out <= pos_dout;
                  vtx_normal_out   <= nrm_dout;
                  vtx_material_out <= mat_dout;
                  vtx_valid_out    <= 1'b1;
                  vtx_last_out     <= (c_q == 2'd2);
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            EMIT: begin
               if (vtx_ready_in) begin
                  vtx_valid_out <= 1'b0;
                  vtx_last_out  <= 1'b0;
                  if (c_q != 2'd2) begin
                     c_q   <= c_q + 2'd1;
                     cnt_q <= 8'(RAM_LATENCY - 1);
                  end else begin
                     c_q <= 2'd0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Address bits above each table's depth are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{seq_addr, corner_q};

endmodule

// File: tb/tb_model_store.sv
// Directed bench for model_store: table loads, vertex fetch timing,
// backpressure, write/fetch arbitration, error pulses and reset mid-fetch.
module tb_model_store;
   import model_pkg::*;

   localparam int L   = 2;
   localparam int GAP = 2*L + 2;

   logic                clk_in = 1'b0;
   logic                rst_in;
   logic                wr_valid_in;
   logic                wr_ready_out;
   logic [1:0]          wr_sel_in;
   logic [11:0]         wr_addr_in;
   logic [95:0]         wr_data_in;
   logic                tri_valid_in;
   logic                tri_ready_out;
   logic [11:0]         tri_id_in;
   logic                vtx_valid_out;
   logic                vtx_ready_in;
   logic [2:0][31:0]    vtx_position_out;
   logic [2:0][31:0]    vtx_normal_out;
   logic [2:0][31:0]    vtx_material_out;
   logic                vtx_last_out;
   logic                err_out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int hs0;

   model_store dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .wr_valid_in      (wr_valid_in),
      .wr_ready_out     (wr_ready_out),
      .wr_sel_in        (wr_sel_in),
      .wr_addr_in       (wr_addr_in),
      .wr_data_in       (wr_data_in),
      .tri_valid_in     (tri_valid_in),
      .tri_ready_out    (tri_ready_out),
      .tri_id_in        (tri_id_in),
      .vtx_valid_out    (vtx_valid_out),
      .vtx_ready_in     (vtx_ready_in),
      .vtx_position_out (vtx_position_out),
      .vtx_normal_out   (vtx_normal_out),
      .vtx_material_out (vtx_material_out),
      .vtx_last_out     (vtx_last_out),
      .err_out          (err_out)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic logic [95:0] mkv(input logic [31:0] b);
      return {b + 32'd2, b + 32'd1, b};
   endfunction

   function automatic logic [95:0] mkc(input int mat, input int nrm, input int pos);
      return {60'd0, 12'(mat), 12'(nrm), 12'(pos)};
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] sel, input logic [11:0] addr, input logic [95:0] data);
      wr_valid_in = 1'b1;
      wr_sel_in   = sel;
      wr_addr_in  = addr;
      wr_data_in  = data;
      tick();
      wr_valid_in = 1'b0;
   endtask

   task automatic start_tri(input string tag, input logic [11:0] id);
      tri_valid_in = 1'b1;
      tri_id_in    = id;
      #1;
      chk({tag, "_tri_ready"}, 96'(tri_ready_out), 96'(1));
      tick();
      tri_valid_in = 1'b0;
      hs0 = cyc;
   endtask

   // Waits for a beat, checks it, and takes it if vtx_ready_in is high.
   // A beat becomes visible GAP-1 edges after the previous handshake edge,
   // so with ready held high the next handshake lands GAP edges later.
   task automatic beat(input string tag, input logic [95:0] ep, input logic [95:0] en,
                       input logic [95:0] em, input logic el);
      int n;
      n = 0;
      while (vtx_valid_out !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 96'(n), 96'(GAP - 1));
      chk({tag, "_pos"},  vtx_position_out, ep);
      chk({tag, "_nrm"},  vtx_normal_out,   en);
      chk({tag, "_mat"},  vtx_material_out, em);
      chk({tag, "_last"}, 96'(vtx_last_out), 96'(el));
      if (vtx_ready_in) tick();
   endtask

   logic [95:0] p0, p1, p2, n0, n1, n2, m0, m1, q6, q7, one3;
   logic        seen;

   initial begin
      p0 = mkv(32'h0100); p1 = mkv(32'h0200); p2 = mkv(32'h0300);
      n0 = mkv(32'h1100); n1 = mkv(32'h1200); n2 = mkv(32'h1300);
      m0 = mkv(32'h2100); m1 = mkv(32'h2200);
      q6 = mkv(32'h0600); q7 = mkv(32'h0700);
      one3 = {3{32'h3F80_0000}};

      rst_in = 1'b1;
      wr_valid_in = 1'b0; wr_sel_in = 2'd0; wr_addr_in = '0; wr_data_in = '0;
      tri_valid_in = 1'b0; tri_id_in = '0; vtx_ready_in = 1'b1;
      repeat (3) tick();
      chk("rst_valid", 96'(vtx_valid_out), 96'(0));
      chk("rst_pos",   vtx_position_out, 96'(0));
      chk("rst_err",   96'(err_out), 96'(0));
      rst_in = 1'b0;
      tick();
      chk("rst_last", 96'(vtx_last_out), 96'(0));
      chk("rst_mat",  vtx_material_out, 96'(0));

      // Table preload
      wr(2'd0, 12'd0, mkc(0, 0, 0));
      wr(2'd0, 12'd1, mkc(0, 1, 1));
      wr(2'd0, 12'd2, mkc(1, 2, 2));
      wr(2'd1, 12'd0, p0); wr(2'd1, 12'd1, p1); wr(2'd1, 12'd2, p2);
      wr(2'd2, 12'd0, n0); wr(2'd2, 12'd1, n1); wr(2'd2, 12'd2, n2);
      wr(2'd3, 12'd0, m0);
      wr(2'd3, 12'd1, m1);
      chk("load_err", 96'(err_out), 96'(0));

      // Basic fetch: handshakes at +6, +12, +18 edges
      start_tri("basic", 12'd0);
      beat("basic0", p0, n0, m0, 1'b0);
      chk("basic0_hs", 96'(cyc - hs0), 96'(GAP));
      beat("basic1", p1, n1, m0, 1'b0);
      beat("basic2", p2, n2, m1, 1'b1);
      chk("basic_total", 96'(cyc - hs0), 96'(3*GAP));

      // Backpressure on beat 0, request issued 1 cycle after last handshake
      vtx_ready_in = 1'b0;
      start_tri("bp", 12'd0);
      beat("bp0", p0, n0, m0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold_valid", 96'(vtx_valid_out), 96'(1));
         chk("bp_hold_pos", vtx_position_out, p0);
      end
      vtx_ready_in = 1'b1;
      tick();
      beat("bp1", p1, n1, m0, 1'b0);
      beat("bp2", p2, n2, m1, 1'b1);

      // Write then fetch: corner 9 is written the cycle before tri 3 is accepted
      wr(2'd1, 12'd5, one3);
      wr(2'd0, 12'd10, mkc(0, 1, 1));
      wr(2'd0, 12'd11, mkc(1, 2, 2));
      wr(2'd0, 12'd9, mkc(0, 0, 5));
      start_tri("wf", 12'd3);
      beat("wf0", one3, n0, m0, 1'b0);
      beat("wf1", p1, n1, m0, 1'b0);
      beat("wf2", p2, n2, m1, 1'b1);

      // Collision: write wins, triangle taken the following cycle
      wr_valid_in = 1'b1; wr_sel_in = 2'd1; wr_addr_in = 12'd6; wr_data_in = q6;
      tri_valid_in = 1'b1; tri_id_in = 12'd0;
      #1;
      chk("col_wr_ready",  96'(wr_ready_out),  96'(1));
      chk("col_tri_ready", 96'(tri_ready_out), 96'(0));
      tick();
      wr_valid_in = 1'b0;
      #1;
      chk("col_tri_next", 96'(tri_ready_out), 96'(1));
      tick();
      tri_valid_in = 1'b0;
      // Write held through the whole fetch stays stalled until IDLE
      wr_valid_in = 1'b1; wr_addr_in = 12'd7; wr_data_in = q7;
      #1;
      chk("busy_wr_ready", 96'(wr_ready_out), 96'(0));
      beat("col0", p0, n0, m0, 1'b0);
      chk("busy_wr_ready_emit", 96'(wr_ready_out), 96'(0));
      beat("col1", p1, n1, m0, 1'b0);
      beat("col2", p2, n2, m1, 1'b1);
      chk("busy_wr_idle", 96'(wr_ready_out), 96'(1));
      tick();
      wr_valid_in = 1'b0;
      wr(2'd0, 12'd12, mkc(0, 0, 6));
      wr(2'd0, 12'd13, mkc(0, 0, 7));
      wr(2'd0, 12'd14, mkc(0, 0, 0));
      start_tri("cv", 12'd4);
      beat("cv0", q6, n0, m0, 1'b0);
      beat("cv1", q7, n0, m0, 1'b0);
      beat("cv2", p0, n0, m0, 1'b1);

      // Error paths
      wr(2'd1, 12'd1024, 96'hDEAD);
      chk("wr_oob_err", 96'(err_out), 96'(1));
      tick();
      chk("wr_oob_err_end", 96'(err_out), 96'(0));
      wr(2'd3, 12'd7, m1);
      chk("mat7_no_err", 96'(err_out), 96'(0));
      wr(2'd3, 12'd8, m0);
      chk("mat8_err", 96'(err_out), 96'(1));
      start_tri("oob", 12'd1365);
      chk("tri_oob_err", 96'(err_out), 96'(1));
      tick();
      chk("tri_oob_err_end", 96'(err_out), 96'(0));
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (vtx_valid_out) seen = 1'b1;
         tick();
      end
      chk("tri_oob_no_beat", 96'(seen), 96'(0));
      start_tri("unchanged", 12'd0);
      beat("unch0", p0, n0, m0, 1'b0);
      beat("unch1", p1, n1, m0, 1'b0);
      beat("unch2", p2, n2, m1, 1'b1);

      // Reset during ATTR_WAIT of corner 1
      start_tri("rm", 12'd0);
      beat("rm0", p0, n0, m0, 1'b0);
      tick();
      tick();
      rst_in = 1'b1;
      #1;
      chk("rm_valid", 96'(vtx_valid_out), 96'(0));
      chk("rm_pos",   vtx_position_out,   96'(0));
      chk("rm_nrm",   vtx_normal_out,     96'(0));
      chk("rm_last",  96'(vtx_last_out),  96'(0));
      tick();
      tick();
      rst_in = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (vtx_valid_out) seen = 1'b1;
         tick();
      end
      chk("rm_no_beat", 96'(seen), 96'(0));
      start_tri("fresh", 12'd0);
      beat("fresh0", p0, n0, m0, 1'b0);
      beat("fresh1", p1, n1, m0, 1'b0);
      beat("fresh2", p2, n2, m1, 1'b1);
      chk("fresh_total", 96'(cyc - hs0), 96'(3*GAP));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
